ps2_host_tx: RTL and testbench

Host-to-device PS/2 command transmitter. Sends one byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the open-drain PS/2 clock/data lines. Sits beside the PS/2 scan-code receiver, which gates its input with `tx_busy`. The receiver's scan-code stream feeds the key-state tracker.

---
 rtl/ps2_host_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 command transmitter. Sends one byte (for example 0xED
// set-LEDs or 0xFF reset) to the keyboard over the open-drain PS/2 clock and
// data lines. The scan-code receiver next to this block ignores the bus while
// tx_busy is high.
//
// A transfer runs as follows. The clock line is held low for INHIBIT_CYCLES
// with data low, which is the start bit. The clock is then released, and the
// device generates falling edges. Edges 1..10 shift out data bits 0..7,
// odd parity and stop. Edge 11 carries the device ACK (data low) or NACK.
// The block then waits for the bus to go idle. A timeout covers the whole
// phase after the clock is released.
//
// Parameters
//   INHIBIT_CYCLES  clock-inhibit length in clk cycles
//   TIMEOUT_CYCLES  max cycles from clock release to end of transfer
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous reset, active low
//   tx_start     in   one-cycle send request, honoured only in IDLE
//   tx_data      in   byte to send, latched when tx_start is accepted
//   ps2_clk_in   in   raw PS/2 clock pin level
//   ps2_data_in  in   raw PS/2 data pin level
//   ps2_clk_oe   out  1 = pull the clock pin low, 0 = release
//   ps2_data_oe  out  1 = pull the data pin low, 0 = release
//   tx_busy      out  high in every state except IDLE
//   tx_done      out  one-cycle pulse at the end of each accepted transfer
//   tx_error     out  qualifies tx_done: 1 = NACK or timeout
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  // The inhibit counter only counts 0..INHIBIT_CYCLES-1.
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t             state;
  logic [9:0]         frame;
  logic [INH_W-1:0]   inh_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [3:0]         edge_cnt;
  logic               result_err;

  logic               ps2_clk_p0;
  logic               ps2_clk_p1;
  logic               ps2_clk_p2;
  logic               ps2_data_p0;
  logic               ps2_data_p1;
  logic               fall;

  // Odd parity: the nine bits data+parity always contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Timeout counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronisers for both pins. Stage p2: one extra
  // clock flop used for falling-edge detection. The flops reset to 1 because
  // an idle PS/2 bus sits high; this avoids a false edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk_in;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= ps2_data_in;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign fall = ps2_clk_p2 & ~ps2_clk_p1;

  // Transfer FSM. All outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      frame       <= '0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      edge_cnt    <= '0;
      result_err  <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_busy     <= 1'b0;
          // The done cycle is already IDLE, so a request in that cycle is
          // held off. A new transfer can start one cycle after tx_done.
          if (tx_start && !tx_done) begin
            frame       <= {1'b1, odd_parity(tx_data), tx_data};
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            edge_cnt    <= '0;
            result_err  <= 1'b0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b1;
            tx_busy     <= 1'b1;
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            // Release the clock. Data stays low, which presents the start bit.
            ps2_clk_oe <= 1'b0;
            tmo_cnt    <= '0;
            state      <= SEND;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        SEND, ACK, WAIT_IDLE: begin
          if (tmo_cnt == TMO_LIMIT) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b1;
            tx_error    <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= sat_inc(tmo_cnt);
            if (state == SEND) begin
              if (fall) begin
                // Open drain: drive low for a 0 bit, release for a 1 bit.
                // Edge 10 presents the stop bit, which releases the line.
                ps2_data_oe <= ~frame[0];
                frame       <= {1'b0, frame[9:1]};
                edge_cnt    <= edge_cnt + 4'd1;
                if (edge_cnt == 4'd9) begin
                  state <= ACK;
                end
              end
            end else if (state == ACK) begin
              if (fall) begin
                edge_cnt   <= edge_cnt + 4'd1;
                result_err <= ps2_data_p1;
                state      <= WAIT_IDLE;
              end
            end else begin
              if (ps2_clk_p1 && ps2_data_p1) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_busy     <= 1'b0;
                tx_done     <= 1'b1;
                tx_error    <= result_err;
                state       <= IDLE;
              end
            end
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_busy     <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx. It contains a behavioural PS/2 device that clocks
// the bus and samples data on rising clock edges. The expected frames come
// from the byte value by plain arithmetic.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 500;
  localparam int HALF = 15;   // device clock half period, in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
  logic       ps2_clk_pin, ps2_data_pin;

  // Open-drain bus: a line is low if either side pulls it low.
  assign ps2_clk_pin  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_pin = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .ps2_clk_in (ps2_clk_pin),
    .ps2_data_in(ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;

  // Completion monitor: counts tx_done pulses and captures what goes with them.
  int   done_cnt = 0;
  logic done_err;
  logic done_oe_any;
  logic busy_after;
  bit   pend = 1'b0;

  always @(negedge clk) begin
    if (pend) begin
      busy_after = tx_busy;
      pend = 1'b0;
    end
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_err = tx_error;
      done_oe_any = ps2_clk_oe | ps2_data_oe;
      pend = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    vectors++;
    assert (obs >= lo && obs <= hi) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference frame as the device should see it on rising edges:
  // start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] expected_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic clear_obs();
    done_err    = 1'bx;
    done_oe_any = 1'bx;
    busy_after  = 1'bx;
  endtask

  // Waits for the done counter to reach target, then lets one more cycle pass
  // so the monitor has recorded tx_busy after the pulse.
  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 1000) begin
      @(negedge clk); #1;
      t++;
    end
    @(negedge clk); #1;
  endtask

  // One transfer against the device model.
  // mode 0: normal, 1: extra tx_start pulse during SEND,
  // 2: reset low after edge 4, 3: device silent (timeout).
  task automatic run_xfer(input logic [7:0] d, input bit ack, input int mode,
                          output logic [10:0] seen, output int inh_len,
                          output int rel_to_done);
    seen = '0;
    inh_len = 0;
    rel_to_done = 0;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("accept_busy", tx_busy, 1);
    while (ps2_clk_oe === 1'b1 && inh_len < 4 * INH) begin
      inh_len++;
      @(negedge clk);
    end
    check("start_bit_held", ps2_data_oe, 1);
    if (mode == 3) begin
      while (tx_done !== 1'b1 && rel_to_done < 4 * TMO) begin
        @(negedge clk);
        rel_to_done++;
      end
      return;
    end
    repeat (5) @(negedge clk);
    seen[0] = ps2_data_pin;
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) begin
        dev_data = 1'b0;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (mode == 1 && e == 3) begin
        check("busy_in_send", tx_busy, 1);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
      if (mode == 2 && e == 4) begin
        reset = 1'b0;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", tx_busy, 0);
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        return;
      end
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (e <= 10) seen[e] = ps2_data_pin;
    end
    dev_data = 1'b1;
  endtask

  logic [10:0] seen;
  int          inh_len;
  int          rel;
  int          base;
  logic [7:0]  d;
  bit          a;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_error", tx_error, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with ACK
    clear_obs();
    base = done_cnt;
    run_xfer(8'hED, 1'b1, 0, seen, inh_len, rel);
    wait_done(base + 1);
    check("ed_inhibit_len", inh_len, INH);
    check("ed_frame", seen, expected_frame(8'hED));
    check("ed_done_count", done_cnt - base, 1);
    check("ed_error", done_err, 0);
    check("ed_oe_at_done", done_oe_any, 0);
    check("ed_busy_after", busy_after, 0);

    // Parity: 0x01 and 0xFF
    clear_obs();
    base = done_cnt;
    run_xfer(8'h01, 1'b1, 0, seen, inh_len, rel);
    wait_done(base + 1);
    check("p01_parity", seen[9], 0);
    check("p01_frame", seen, expected_frame(8'h01));
    check("p01_error", done_err, 0);

    clear_obs();
    base = done_cnt;
    run_xfer(8'hFF, 1'b1, 0, seen, inh_len, rel);
    wait_done(base + 1);
    check("pff_parity", seen[9], 1);
    check("pff_frame", seen, expected_frame(8'hFF));
    check("pff_error", done_err, 0);

    // NACK
    clear_obs();
    base = done_cnt;
    d = 8'($urandom);
    run_xfer(d, 1'b0, 0, seen, inh_len, rel);
    wait_done(base + 1);
    check("nack_frame", seen, expected_frame(d));
    check("nack_done_count", done_cnt - base, 1);
    check("nack_error", done_err, 1);
    check("nack_clk_oe", ps2_clk_oe, 0);
    check("nack_data_oe", ps2_data_oe, 0);

    // Timeout: the device never clocks
    clear_obs();
    base = done_cnt;
    run_xfer(8'hFF, 1'b1, 3, seen, inh_len, rel);
    wait_done(base + 1);
    check_range("tmo_delay", rel, TMO - 1, TMO + 1);
    check("tmo_done_count", done_cnt - base, 1);
    check("tmo_error", done_err, 1);
    check("tmo_oe_at_done", done_oe_any, 0);
    check("tmo_busy_after", busy_after, 0);

    // Start while busy
    clear_obs();
    base = done_cnt;
    run_xfer(8'hED, 1'b1, 1, seen, inh_len, rel);
    wait_done(base + 1);
    check("busy_start_frame", seen, expected_frame(8'hED));
    check("busy_start_error", done_err, 0);
    repeat (100) @(negedge clk);
    check("busy_start_one_done", done_cnt - base, 1);
    check("busy_start_idle", tx_busy, 0);
    check("busy_start_clk_oe", ps2_clk_oe, 0);

    // Reset mid-transfer, then a fresh transfer
    clear_obs();
    base = done_cnt;
    run_xfer(8'hA5, 1'b1, 2, seen, inh_len, rel);
    repeat (100) @(negedge clk);
    #1;
    check("rst_no_done", done_cnt - base, 0);
    check("rst_idle_busy", tx_busy, 0);
    check("rst_idle_clk_oe", ps2_clk_oe, 0);

    clear_obs();
    base = done_cnt;
    run_xfer(8'hF4, 1'b1, 0, seen, inh_len, rel);
    wait_done(base + 1);
    check("f4_frame", seen, expected_frame(8'hF4));
    check("f4_done_count", done_cnt - base, 1);
    check("f4_error", done_err, 0);

    // Randomised bytes with random ACK/NACK
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      clear_obs();
      base = done_cnt;
      run_xfer(d, a, 0, seen, inh_len, rel);
      wait_done(base + 1);
      check("rnd_inhibit_len", inh_len, INH);
      check("rnd_frame", seen, expected_frame(d));
      check("rnd_done_count", done_cnt - base, 1);
      check("rnd_error", done_err, {31'd0, ~a});
      check("rnd_busy_after", busy_after, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
